// File: rtl/ysyx_idu_pkg.sv
// Shared decode definitions for the instruction decode unit.
// Holds the op_class encodings, the RV32I major opcode constants, the reset
// nop, and a helper that maps a raw instruction word to its op_class.
package ysyx_idu_pkg;

  typedef enum logic [3:0] {
    OPC_LUI     = 4'd0,
    OPC_AUIPC   = 4'd1,
    OPC_JAL     = 4'd2,
    OPC_JALR    = 4'd3,
    OPC_BRANCH  = 4'd4,
    OPC_LOAD    = 4'd5,
    OPC_STORE   = 4'd6,
    OPC_OPIMM   = 4'd7,
    OPC_OP      = 4'd8,
    OPC_FENCE   = 4'd9,
    OPC_SYSTEM  = 4'd10,
    OPC_ILLEGAL = 4'd15
  } op_class_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Full 7-bit opcode match; the two low bits being anything other than
  // 2'b11 therefore falls through to ILLEGAL on its own.
  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e c;
    case (opcode)
      OP_LUI:    c = OPC_LUI;
      OP_AUIPC:  c = OPC_AUIPC;
      OP_JAL:    c = OPC_JAL;
      OP_JALR:   c = OPC_JALR;
      OP_BRANCH: c = OPC_BRANCH;
      OP_LOAD:   c = OPC_LOAD;
      OP_STORE:  c = OPC_STORE;
      OP_OPIMM:  c = OPC_OPIMM;
      OP_OP:     c = OPC_OP;
      OP_FENCE:  c = OPC_FENCE;
      OP_SYSTEM: c = OPC_SYSTEM;
      default:   c = OPC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_idu_immgen.sv
// Immediate generator: purely combinational.
//   inst : instruction word
//   imm  : sign-extended I/S/B/J immediate, U immediate in the upper 20 bits,
//          zero for R-type and unrecognised opcodes
module ysyx_idu_immgen
  import ysyx_idu_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM, OP_FENCE:
        imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {inst[31:12], 12'b0};
      OP_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_idu.sv
// Instruction decode unit with a one-entry holding register and a 32-entry
// register busy scoreboard.
//   clk, rst            : clock, synchronous active-high reset
//   prev_valid, ready_o : fetch-side handshake (ready_o = holding reg empty)
//   inst, pc            : fetched instruction and its PC
//   valid_o, next_ready : execute-side handshake
//   wb_valid, wb_rd     : writeback retire, clears busy[wb_rd]
//   flush               : drop the held instruction
//   rd/rs1/rs2, imm, op_class, alu_op, pc_o, illegal : decoded fields
module ysyx_idu
  import ysyx_idu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  output logic              valid_o,
  input  logic              next_ready,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [DATA_W-1:0] imm,
  output logic [3:0]        op_class,
  output logic [3:0]        alu_op,
  output logic [ADDR_W-1:0] pc_o,
  output logic              illegal
);

  logic              held_valid;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       busy_q;
  logic [31:0]       busy_d;

  op_class_e cls;
  logic [2:0] funct3;
  logic rs1_used, rs2_used, rd_wr, hazard, fire, capture;

  assign ready_o = !held_valid;
  assign capture = prev_valid && ready_o;
  assign fire    = valid_o && next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      inst_q     <= DATA_W'(INST_NOP);
      pc_q       <= '0;
    end else if (flush || fire) begin
      held_valid <= 1'b0;
    end else if (capture) begin
      held_valid <= 1'b1;
      inst_q     <= inst;
      pc_q       <= pc;
    end
  end

  always_comb begin
    cls      = classify(inst_q[6:0]);
    funct3   = inst_q[14:12];
    rd       = inst_q[11:7];
    rs1      = inst_q[19:15];
    rs2      = inst_q[24:20];
    illegal  = (cls == OPC_ILLEGAL);
    // inst[30] only selects SUB/SRA for register ops and SRAI for immediates;
    // for other I-type ops those bits belong to the immediate.
    if (cls == OPC_OP || (cls == OPC_OPIMM && funct3 == 3'b101))
      alu_op = {inst_q[30], funct3};
    else
      alu_op = {1'b0, funct3};
    rs1_used = !(cls inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE});
    rs2_used = cls inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    // SYSTEM writes rd only for the CSR forms (funct3 != 0).
    rd_wr    = (rd != 5'd0) &&
               ((cls inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                             OPC_LOAD, OPC_OPIMM, OPC_OP}) ||
                (cls == OPC_SYSTEM && funct3 != 3'b000));
    hazard   = (rs1_used && busy_q[rs1]) ||
               (rs2_used && busy_q[rs2]) ||
               (rd_wr && busy_q[rd]);
    valid_o  = held_valid && !hazard;
  end

  assign op_class = cls;
  assign pc_o     = pc_q;

  ysyx_idu_immgen u_immgen (
    .inst (inst_q),
    .imm  (imm)
  );

  // Clear is applied before set so an issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_rd] = 1'b0;
    if (fire && rd_wr)
      busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: tb/tb_ysyx_idu.sv
module tb_ysyx_idu;

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid_o;
  logic        next_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [3:0]  op_class;
  logic [3:0]  alu_op;
  logic [31:0] pc_o;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_idu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .prev_valid (prev_valid),
    .ready_o    (ready_o),
    .inst       (inst),
    .pc         (pc),
    .valid_o    (valid_o),
    .next_ready (next_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .op_class   (op_class),
    .alu_op     (alu_op),
    .pc_o       (pc_o),
    .illegal    (illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        ill;
    logic        wr;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // capture then fire with next_ready held high
  task automatic issue(input logic [31:0] word);
    next_ready = 1'b1;
    prev_valid = 1'b1;
    inst       = word;
    tick();
    prev_valid = 1'b0;
    tick();
  endtask

  task automatic retire(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    //           inst          cls  rd  rs1 rs2 imm           alu ill wr
    vecs[0]  = '{32'h00500093, 4'd7, 5'd1, 5'd0, 5'd5, 32'h00000005, 4'd0, 1'b0, 1'b1};
    vecs[1]  = '{32'h00108133, 4'd8, 5'd2, 5'd1, 5'd1, 32'h00000000, 4'd0, 1'b0, 1'b1};
    vecs[2]  = '{32'h123452B7, 4'd0, 5'd5, 5'd8, 5'd3, 32'h12345000, 4'd5, 1'b0, 1'b1};
    vecs[3]  = '{32'h00000000, 4'd15, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'd0, 1'b1, 1'b0};
    vecs[4]  = '{32'h4041D193, 4'd7, 5'd3, 5'd3, 5'd4, 32'h00000404, 4'd13, 1'b0, 1'b1};
    vecs[5]  = '{32'h0020A423, 4'd6, 5'd8, 5'd1, 5'd2, 32'h00000008, 4'd2, 1'b0, 1'b0};
    vecs[6]  = '{32'hFE000EE3, 4'd4, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{32'h008000EF, 4'd2, 5'd1, 5'd0, 5'd8, 32'h00000008, 4'd0, 1'b0, 1'b1};
    vecs[8]  = '{32'hFFF12303, 4'd5, 5'd6, 5'd2, 5'd31, 32'hFFFFFFFF, 4'd2, 1'b0, 1'b1};
    vecs[9]  = '{32'h00500090, 4'd15, 5'd1, 5'd0, 5'd5, 32'h00000000, 4'd0, 1'b1, 1'b0};
    vecs[10] = '{32'h300023F3, 4'd10, 5'd7, 5'd0, 5'd0, 32'h00000300, 4'd2, 1'b0, 1'b1};
    vecs[11] = '{32'h00000073, 4'd10, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'd0, 1'b0, 1'b0};
    vecs[12] = '{32'h00001517, 4'd1, 5'd10, 5'd0, 5'd0, 32'h00001000, 4'd1, 1'b0, 1'b1};

    rst = 1'b1; prev_valid = 1'b0; inst = '0; pc = '0; next_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst ready_o", 32'(ready_o), 32'd1);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst op_class", 32'(op_class), 32'd7);
    chk("rst imm", imm, 32'd0);
    chk("rst rd/rs1/rs2", {17'd0, rd, rs1, rs2}, 32'd0);
    chk("rst pc_o", pc_o, 32'd0);
    chk("rst busy", dut.busy_q, 32'd0);

    // decode table: capture, check fields, fire, check scoreboard, retire
    for (int i = 0; i < 13; i++) begin
      next_ready = 1'b0;
      prev_valid = 1'b1;
      inst       = vecs[i].inst;
      pc         = 32'h8000_0000 + 32'(i * 4);
      tick();
      prev_valid = 1'b0;
      chk($sformatf("v%0d valid_o", i), 32'(valid_o), 32'd1);
      chk($sformatf("v%0d ready_o", i), 32'(ready_o), 32'd0);
      chk($sformatf("v%0d op_class", i), 32'(op_class), 32'(vecs[i].cls));
      chk($sformatf("v%0d rd", i), 32'(rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d rs1", i), 32'(rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d rs2", i), 32'(rs2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d pc_o", i), pc_o, 32'h8000_0000 + 32'(i * 4));
      next_ready = 1'b1;
      tick();
      next_ready = 1'b0;
      chk($sformatf("v%0d post-fire valid_o", i), 32'(valid_o), 32'd0);
      chk($sformatf("v%0d post-fire ready_o", i), 32'(ready_o), 32'd1);
      chk($sformatf("v%0d busy", i), dut.busy_q,
          vecs[i].wr ? (32'd1 << vecs[i].rd) : 32'd0);
      retire(vecs[i].rd);
      chk($sformatf("v%0d busy after wb", i), dut.busy_q, 32'd0);
    end

    // RAW stall: add x2,x1,x1 behind addi x1
    issue(32'h00500093);
    chk("raw busy1", dut.busy_q, 32'h2);
    prev_valid = 1'b1; inst = 32'h00108133;
    tick();
    prev_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("raw stalled valid_o", 32'(valid_o), 32'd0);
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd1;
    chk("raw wb cycle valid_o", 32'(valid_o), 32'd0);
    tick();
    wb_valid = 1'b0;
    chk("raw released valid_o", 32'(valid_o), 32'd1);
    chk("raw busy cleared", dut.busy_q, 32'd0);
    tick();
    chk("raw add fired busy", dut.busy_q, 32'h4);
    retire(5'd2);

    // lui has no source operands: not blocked by busy x1/x3/x8
    issue(32'h00000413);
    issue(32'h00000193);
    issue(32'h00500093);
    chk("lui pre busy", dut.busy_q, 32'h10A);
    prev_valid = 1'b1; inst = 32'h123452B7;
    tick();
    prev_valid = 1'b0;
    chk("lui valid_o", 32'(valid_o), 32'd1);
    chk("lui imm", imm, 32'h12345000);
    chk("lui rd", 32'(rd), 32'd5);
    tick();
    chk("lui busy", dut.busy_q, 32'h12A);
    retire(5'd1); retire(5'd3); retire(5'd5); retire(5'd8);
    chk("lui busy cleared", dut.busy_q, 32'd0);

    // same-cycle fire and writeback to the same register: set wins
    next_ready = 1'b1;
    prev_valid = 1'b1; inst = 32'h00500093;
    tick();
    prev_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd1;
    tick();
    wb_valid = 1'b0;
    chk("set-wins busy", dut.busy_q, 32'h2);
    retire(5'd1);
    issue(32'h00000013);
    chk("x0 never busy", dut.busy_q, 32'd0);

    // backpressure hold then flush
    issue(32'h00000193);
    next_ready = 1'b0;
    prev_valid = 1'b1; inst = 32'h00500093;
    tick();
    inst = 32'h00000000;
    for (int k = 0; k < 5; k++) begin
      chk("hold ready_o", 32'(ready_o), 32'd0);
      chk("hold valid_o", 32'(valid_o), 32'd1);
      chk("hold imm", imm, 32'd5);
      chk("hold rd/illegal", {26'd0, rd, illegal}, {26'd0, 5'd1, 1'b0});
      tick();
    end
    flush = 1'b1;
    tick();
    chk("flush valid_o", 32'(valid_o), 32'd0);
    chk("flush ready_o", 32'(ready_o), 32'd1);
    chk("flush busy kept", dut.busy_q, 32'h8);
    tick();
    chk("flush beats capture", 32'(valid_o), 32'd0);
    chk("flush beats capture ready", 32'(ready_o), 32'd1);
    flush = 1'b0; prev_valid = 1'b0;
    retire(5'd3);

    // srai decode, then reset while stalled behind a busy register
    issue(32'h00500093);
    next_ready = 1'b0;
    prev_valid = 1'b1; inst = 32'h4041D193;
    tick();
    prev_valid = 1'b0;
    chk("srai alu_op", 32'(alu_op), 32'hD);
    prev_valid = 1'b0;
    next_ready = 1'b1;
    tick();
    next_ready = 1'b0;
    prev_valid = 1'b1; inst = 32'h00108133;
    tick();
    prev_valid = 1'b0;
    next_ready = 1'b1;
    chk("pre-rst stalled", 32'(valid_o), 32'd0);
    chk("pre-rst busy", dut.busy_q, 32'hA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    next_ready = 1'b0;
    chk("mid-rst valid_o", 32'(valid_o), 32'd0);
    chk("mid-rst ready_o", 32'(ready_o), 32'd1);
    chk("mid-rst busy", dut.busy_q, 32'd0);
    chk("mid-rst op_class", 32'(op_class), 32'd7);
    chk("mid-rst imm", imm, 32'd0);
    chk("mid-rst rd", 32'(rd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
